// File: rtl/feed_pkg.sv
// Shared types and sizing for the west-edge feed scheduler.
// Row count, FIFO depth and tile limit are fixed here so every file sizes its buses identically.
package feed_pkg;
  localparam int N_ROWS  = 4;
  localparam int DEPTH   = 8;
  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int TW      = $clog2(MAX_LEN + N_ROWS);
  localparam int RW      = $clog2(N_ROWS);
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/feed_row_win.sv
// Per-row slice: write counter, loader-ready term, fill threshold and skew window.
// Row ROW is read while ROW <= t < ROW+len.
module feed_row_win
  import feed_pkg::*;
#(
  parameter int ROW = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic          i_full,
  input  logic [LW-1:0] i_len,
  input  logic [TW-1:0] i_t,
  output logic          o_ready,
  output logic          o_filled,
  output logic          o_active
);
  logic [LW-1:0] r_wcnt;
  logic [LW-1:0] w_fill_tgt;
  logic [TW:0]   w_t;
  logic [TW:0]   w_lo;
  logic [TW:0]   w_hi;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_wcnt <= '0;
    else if (i_clr) r_wcnt <= '0;
    else if (i_wr)  r_wcnt <= r_wcnt + 1'b1;
  end

  // Prefill never waits for more than the FIFO can hold; longer tiles refill while streaming.
  assign w_fill_tgt = (i_len < LW'(DEPTH - 1)) ? i_len : LW'(DEPTH - 1);
  assign o_filled   = (r_wcnt >= w_fill_tgt);
  assign o_ready    = !i_full && (r_wcnt < i_len);

  assign w_t      = {1'b0, i_t};
  assign w_lo     = (TW+1)'(ROW);
  assign w_hi     = w_lo + (TW+1)'(i_len);
  assign o_active = (w_t >= w_lo) && (w_t < w_hi);
endmodule

// File: rtl/feed_sched.sv
// Row-FIFO scheduler for the systolic array's west edge: gates loader writes,
// skews reads diagonally, freezes the wavefront on any dry active row, flushes between tiles.
module feed_sched
  import feed_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [LW-1:0]       tile_len,
  input  logic                abort,
  input  logic                ld_valid,
  input  logic [RW-1:0]       ld_row,
  output logic                ld_ready,
  output logic [N_ROWS-1:0]   buf_wr_en,
  output logic [N_ROWS-1:0]   buf_rd_en,
  input  logic [N_ROWS-1:0]   buf_empty,
  input  logic [N_ROWS-1:0]   buf_full,
  output logic                buf_flush,
  output logic                busy,
  output logic                done,
  output logic [STALL_W-1:0]  stall_cnt
);
  state_t             r_state;
  logic [LW-1:0]      r_len;
  logic [TW-1:0]      r_t;
  logic [STALL_W-1:0] r_stall;
  logic               r_flush;

  logic [N_ROWS-1:0]  w_row_ready;
  logic [N_ROWS-1:0]  w_filled;
  logic [N_ROWS-1:0]  w_active;
  logic               w_start_ok;
  logic               w_clr;
  logic               w_wr_win;
  logic               w_wr;
  logic               w_adv;
  logic               w_last;
  logic [TW-1:0]      w_t_end;

  assign w_start_ok = start && (tile_len != '0) && (tile_len <= LW'(MAX_LEN));
  assign w_clr      = (r_state == IDLE) && w_start_ok;

  // The flush cycle is kept write-free so no word lands in a FIFO that is being reset.
  assign w_wr_win  = ((r_state == FILL) || (r_state == STREAM)) && !r_flush;
  assign ld_ready  = w_wr_win && w_row_ready[ld_row];
  assign w_wr      = ld_valid && ld_ready;
  assign buf_wr_en = w_wr ? (N_ROWS'(1) << ld_row) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_row
      feed_row_win #(.ROW(gi)) u_row (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (w_clr),
        .i_wr     (buf_wr_en[gi]),
        .i_full   (buf_full[gi]),
        .i_len    (r_len),
        .i_t      (r_t),
        .o_ready  (w_row_ready[gi]),
        .o_filled (w_filled[gi]),
        .o_active (w_active[gi])
      );
    end
  endgenerate

  assign w_adv     = ~|(w_active & buf_empty);
  assign w_t_end   = TW'(r_len) + TW'(N_ROWS - 2);
  assign w_last    = (r_t == w_t_end);
  assign buf_rd_en = ((r_state == STREAM) && w_adv) ? w_active : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_t     <= '0;
      r_stall <= '0;
      r_flush <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_len   <= tile_len;
            r_t     <= '0;
            r_stall <= '0;
            r_flush <= 1'b1;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            r_flush <= 1'b1;
            r_state <= IDLE;
          end else if (&w_filled) begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          // Abort wins even over the final step, so a cancelled tile never reports done.
          if (abort) begin
            r_flush <= 1'b1;
            r_state <= IDLE;
          end else if (w_adv) begin
            r_t <= r_t + 1'b1;
            if (w_last) r_state <= DONE;
          end else if (r_stall != '1) begin
            r_stall <= r_stall + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign buf_flush = r_flush;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign stall_cnt = r_stall;
endmodule

// File: tb/tb_feed_sched.sv
// Directed bench for feed_sched with a counting FIFO model driving the empty/full flags.
module tb_feed_sched;
  import feed_pkg::*;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic [LW-1:0]       tile_len = '0;
  logic                abort = 1'b0;
  logic                ld_valid = 1'b0;
  logic [RW-1:0]       ld_row = '0;
  logic                ld_ready;
  logic [N_ROWS-1:0]   buf_wr_en;
  logic [N_ROWS-1:0]   buf_rd_en;
  logic [N_ROWS-1:0]   buf_empty;
  logic [N_ROWS-1:0]   buf_full;
  logic                buf_flush;
  logic                busy;
  logic                done;
  logic [STALL_W-1:0]  stall_cnt;

  logic [N_ROWS-1:0]   inj = '0;
  logic [N_ROWS-1:0]   m_empty;
  logic [N_ROWS-1:0]   m_full;
  int                  mcnt [N_ROWS];
  int                  n_vec = 0;
  int                  n_err = 0;
  int                  done_seen = 0;

  feed_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .tile_len(tile_len), .abort(abort),
    .ld_valid(ld_valid), .ld_row(ld_row), .ld_ready(ld_ready),
    .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .buf_empty(buf_empty),
    .buf_full(buf_full), .buf_flush(buf_flush), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_empty = '0;
    m_full  = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      m_empty[i] = (mcnt[i] == 0);
      m_full[i]  = (mcnt[i] >= DEPTH - 1);
    end
  end
  assign buf_empty = m_empty | inj;
  assign buf_full  = m_full;

  initial for (int i = 0; i < N_ROWS; i++) mcnt[i] = 0;
  always @(posedge clk) begin
    for (int i = 0; i < N_ROWS; i++) begin
      if (buf_flush) mcnt[i] <= 0;
      else mcnt[i] <= mcnt[i] + int'(buf_wr_en[i]) - int'(buf_rd_en[i]);
    end
  end

  always @(negedge clk) if (done) done_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {logic [N_ROWS-1:0] inj; logic [N_ROWS-1:0] rd;} svec_t;
  typedef struct {logic [LW-1:0] len; logic acc;} stvec_t;
  svec_t  nom_tab [$];
  svec_t  stall_tab [$];
  svec_t  len2_tab [$];
  svec_t  cur [$];
  stvec_t st_tab [$];

  task automatic do_start(input logic [LW-1:0] len);
    @(negedge clk); start = 1'b1; tile_len = len;
    @(negedge clk); start = 1'b0; #1;
  endtask

  task automatic load(input int len);
    for (int w = 0; w < len; w++)
      for (int r = 0; r < N_ROWS; r++) begin
        int n;
        @(negedge clk); ld_valid = 1'b1; ld_row = RW'(r); #1;
        n = 0;
        while (!ld_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!ld_ready) chk($sformatf("load_timeout_r%0d", r), 32'(ld_ready), 1);
      end
    @(negedge clk); ld_valid = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (buf_rd_en != '0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("stream_start_timeout", 0, 1);
  endtask

  task automatic run_stream(input int exp_stall);
    bit ok;
    wait_rd(ok);
    if (ok) begin
      chk("rd_k0", 32'(buf_rd_en), 32'(cur[0].rd));
      for (int k = 1; k < cur.size(); k++) begin
        @(negedge clk); inj = cur[k].inj; #1;
        chk($sformatf("rd_k%0d", k), 32'(buf_rd_en), 32'(cur[k].rd));
      end
      @(negedge clk); inj = '0; #1;
      chk("done_pulse", 32'(done), 1);
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      @(negedge clk); #1;
      chk("idle_after_done", 32'({busy, done}), 0);
    end
  endtask

  initial begin
    int d0;
    bit ok;
    int wc [N_ROWS];
    int rc [N_ROWS];
    int viol, under, got_done;

    nom_tab = '{'{4'b0000, 4'b0001}, '{4'b0000, 4'b0011}, '{4'b0000, 4'b0111},
                '{4'b0000, 4'b1110}, '{4'b0000, 4'b1100}, '{4'b0000, 4'b1000}};
    stall_tab = '{'{4'b0000, 4'b0001}, '{4'b0000, 4'b0011},
                  '{4'b0100, 4'b0000}, '{4'b0100, 4'b0000}, '{4'b0100, 4'b0000},
                  '{4'b0100, 4'b0000}, '{4'b0000, 4'b0111}, '{4'b0000, 4'b1110},
                  '{4'b0000, 4'b1100}, '{4'b0000, 4'b1000}};
    len2_tab = '{'{4'b0000, 4'b0001}, '{4'b0000, 4'b0011}, '{4'b0000, 4'b0110},
                 '{4'b0000, 4'b1100}, '{4'b0000, 4'b1000}};
    st_tab = '{'{5'd0, 1'b0}, '{5'd17, 1'b0}, '{5'd31, 1'b0}, '{5'd1, 1'b1}, '{5'd16, 1'b1}};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flush", 32'(buf_flush), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_rd", 32'(buf_rd_en), 0);
    @(negedge clk); rstn = 1'b1;
    ld_valid = 1'b1; #1;
    chk("idle_ld_ready", 32'({ld_ready, buf_wr_en}), 0);
    ld_valid = 1'b0;

    // start acceptance table
    foreach (st_tab[v]) begin
      d0 = done_seen;
      do_start(st_tab[v].len);
      chk($sformatf("start_busy_len%0d", st_tab[v].len), 32'(busy), 32'(st_tab[v].acc));
      chk($sformatf("start_flush_len%0d", st_tab[v].len), 32'(buf_flush), 32'(st_tab[v].acc));
      if (st_tab[v].acc) begin
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        chk("abort_fill_idle", 32'({busy, buf_flush}), 32'b01);
      end
      chk("start_no_done", 32'(done_seen), 32'(d0));
    end

    // Nominal len=3 tile
    cur = nom_tab;
    do_start(3); load(3); run_stream(0);

    // Row 2 starved for 4 cycles while active
    cur = stall_tab;
    do_start(3); load(3); run_stream(4);

    // Abort at t=2, then a len=2 tile
    d0 = done_seen;
    do_start(3); load(3); wait_rd(ok);
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    chk("abort_stream", 32'({busy, buf_flush, done}), 32'b010);
    @(negedge clk); #1;
    chk("abort_flush_once", 32'({busy, buf_flush}), 0);
    chk("abort_no_done", 32'(done_seen), 32'(d0));
    cur = len2_tab;
    do_start(2); load(2); run_stream(0);

    // Reset mid-STREAM, then a clean tile
    do_start(3); load(3); wait_rd(ok);
    @(negedge clk); #2; rstn = 1'b0; #1;
    chk("midrst_outs", 32'({busy, done, buf_flush, ld_ready, buf_rd_en, buf_wr_en}), 0);
    chk("midrst_stall", 32'(stall_cnt), 0);
    @(negedge clk); rstn = 1'b1;
    cur = nom_tab;
    do_start(3); load(3); run_stream(0);

    // len=12: refill while streaming through DEPTH-1 deep FIFOs
    for (int i = 0; i < N_ROWS; i++) begin wc[i] = 0; rc[i] = 0; end
    viol = 0; under = 0; got_done = 0;
    do_start(12);
    fork
      begin : loader
        int r;
        r = 0;
        for (int n = 0; n < 600; n++) begin
          bit all;
          all = 1'b1;
          for (int i = 0; i < N_ROWS; i++) if (wc[i] < 12) all = 1'b0;
          if (all) break;
          @(negedge clk); ld_valid = 1'b1; ld_row = RW'(r); #1;
          if (ld_ready !== (!m_full[r] && wc[r] < 12)) viol++;
          if (ld_ready) begin
            wc[r]++;
            for (int j = 0; j < N_ROWS; j++) begin
              r = (r + 1) % N_ROWS;
              if (wc[r] < 12) break;
            end
          end
        end
        @(negedge clk); ld_valid = 1'b0;
      end
      begin : observer
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
          @(negedge clk); #2;
          if (buf_rd_en != '0 && !seen) begin
            seen = 1'b1;
            for (int i = 0; i < N_ROWS; i++)
              chk($sformatf("fill_exit_wcnt_r%0d", i), 32'(wc[i]), 7);
          end
          for (int i = 0; i < N_ROWS; i++)
            if (buf_rd_en[i]) begin
              rc[i]++;
              if (m_empty[i]) under++;
            end
          if (done) begin got_done = 1; break; end
        end
      end
    join
    chk("len12_done", 32'(got_done), 1);
    chk("len12_ready_rule", 32'(viol), 0);
    chk("len12_underflow", 32'(under), 0);
    for (int i = 0; i < N_ROWS; i++) begin
      chk($sformatf("len12_writes_r%0d", i), 32'(wc[i]), 12);
      chk($sformatf("len12_reads_r%0d", i), 32'(rc[i]), 12);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
